// File: rtl/herald_host_if.sv
// herald_host_if -- byte-wide peripheral bus between herald_host and its peripheral.
//   bus_data : host -> peripheral data byte
//   bus_wr   : host -> peripheral write strobe
//   bus_rd   : host -> peripheral read strobe
//   bus_in   : peripheral -> host output byte, bit 7 = BUSY
interface herald_host_if;
    logic [7:0] bus_data;
    logic       bus_wr;
    logic       bus_rd;
    logic [7:0] bus_in;

    modport master (
        output bus_data,
        output bus_wr,
        output bus_rd,
        input  bus_in
    );

    modport slave (
        input  bus_data,
        input  bus_wr,
        input  bus_rd,
        output bus_in
    );
endinterface

// File: rtl/herald_host.sv
// herald_host -- command sequencer for a strobed byte-wide arithmetic peripheral.
// Accepts a command with two Q12.12 operands, writes the command byte and the
// required operand bytes, waits for BUSY to drop (with timeout), reads back the
// result bytes and reports done/err.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               launch request, sampled only while ready=1
//   cmd, op_a, op_b     command code and operands, latched on acceptance
//   ready               host idle
//   done, err           one-cycle completion / rejection-or-timeout pulses
//   result              read bytes packed LSB-first, zero-extended
//   bus                 peripheral bus (master side)
module herald_host #(
    parameter int unsigned STROBE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    cmd,
    input  logic [23:0]   op_a,
    input  logic [23:0]   op_b,
    output logic          ready,
    output logic          done,
    output logic          err,
    output logic [71:0]   result,
    herald_host_if.master bus
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // One byte transfer spans phase counts 0..2*STROBE_CYCLES-1; strobe is high
    // for counts 0..STROBE_CYCLES-1.
    localparam logic [4:0]    PH_HI_LAST = 5'(STROBE_CYCLES - 1);
    localparam logic [4:0]    PH_END     = 5'(2 * STROBE_CYCLES - 1);
    // Read data is taken one clock after bus_rd rises.
    localparam logic [4:0]    PH_CAP     = 5'd1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_WR_OPS,
        ST_WAIT_BUSY,
        ST_RD_BYTES,
        ST_FINISH
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic          r_done;
    logic          r_err;
    logic [71:0]   r_result;
    logic [7:0]    r_data;
    logic          r_wr;
    logic          r_rd;
    logic [4:0]    r_ph;
    logic [3:0]    r_idx;
    logic [TW-1:0] r_tmo;
    logic [23:0]   r_a;
    logic [23:0]   r_b;
    logic [3:0]    r_nops;
    logic [3:0]    r_nrd;

    logic          w_dec_ok;
    logic [3:0]    w_dec_ops;
    logic [3:0]    w_dec_rd;
    logic [3:0]    w_nxt_idx;
    logic [7:0]    w_op_byte;

    // Operand byte count (0, 3 or 6) and result byte count per command.
    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_ops = 4'd0;
        w_dec_rd  = 4'd0;
        case (cmd)
            8'h10:                      begin w_dec_ops = 4'd3; w_dec_rd = 4'd6; end
            8'h11, 8'h12, 8'h20, 8'h21: begin w_dec_ops = 4'd6; w_dec_rd = 4'd3; end
            8'h13:                      begin w_dec_ops = 4'd6; w_dec_rd = 4'd9; end
            8'h23:                      begin w_dec_ops = 4'd3; w_dec_rd = 4'd3; end
            8'h22:                      begin w_dec_ops = 4'd0; w_dec_rd = 4'd0; end
            default:                    w_dec_ok = 1'b0;
        endcase
    end

    // Byte to load for the next operand write (index r_idx+1 of A0..A2,B0..B2).
    always_comb begin
        w_nxt_idx = r_idx + 4'd1;
        w_op_byte = '0;
        case (w_nxt_idx)
            4'd1:    w_op_byte = r_a[15:8];
            4'd2:    w_op_byte = r_a[23:16];
            4'd3:    w_op_byte = r_b[7:0];
            4'd4:    w_op_byte = r_b[15:8];
            4'd5:    w_op_byte = r_b[23:16];
            default: w_op_byte = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_data   <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_ph     <= '0;
            r_idx    <= '0;
            r_tmo    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_nops   <= '0;
            r_nrd    <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (start) begin
                        r_result <= '0;
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_nops   <= w_dec_ops;
                        r_nrd    <= w_dec_rd;
                        if (w_dec_ok) begin
                            r_state <= ST_WR_CMD;
                            r_ready <= 1'b0;
                            r_data  <= cmd;
                            r_wr    <= 1'b1;
                            r_ph    <= '0;
                        end else begin
                            // Unknown command: reject without touching the bus.
                            r_err <= 1'b1;
                        end
                    end
                end

                ST_WR_CMD: begin
                    r_ph <= r_ph + 5'd1;
                    if (r_ph == PH_HI_LAST) r_wr <= 1'b0;
                    if (r_ph == PH_END) begin
                        r_ph <= '0;
                        if (r_nops != 4'd0) begin
                            r_state <= ST_WR_OPS;
                            r_idx   <= '0;
                            r_data  <= r_a[7:0];
                            r_wr    <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_BUSY;
                            r_tmo   <= '0;
                        end
                    end
                end

                ST_WR_OPS: begin
                    r_ph <= r_ph + 5'd1;
                    if (r_ph == PH_HI_LAST) r_wr <= 1'b0;
                    if (r_ph == PH_END) begin
                        r_ph <= '0;
                        if (r_idx == r_nops - 4'd1) begin
                            r_state <= ST_WAIT_BUSY;
                            r_tmo   <= '0;
                        end else begin
                            r_idx  <= w_nxt_idx;
                            r_data <= w_op_byte;
                            r_wr   <= 1'b1;
                        end
                    end
                end

                ST_WAIT_BUSY: begin
                    if (!bus.bus_in[7]) begin
                        if (r_nrd == 4'd0) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RD_BYTES;
                            r_rd    <= 1'b1;
                            r_ph    <= '0;
                            r_idx   <= '0;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end

                ST_RD_BYTES: begin
                    r_ph <= r_ph + 5'd1;
                    if (r_ph == PH_CAP) begin
                        for (int unsigned k = 0; k < 9; k++) begin
                            if (r_idx == 4'(k)) r_result[8*k +: 8] <= bus.bus_in;
                        end
                    end
                    if (r_ph == PH_HI_LAST) r_rd <= 1'b0;
                    if (r_ph == PH_END) begin
                        r_ph <= '0;
                        if (r_idx == r_nrd - 4'd1) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                            r_rd  <= 1'b1;
                        end
                    end
                end

                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_wr    <= 1'b0;
                    r_rd    <= 1'b0;
                end
            endcase
        end
    end

    assign ready        = r_ready;
    assign done         = r_done;
    assign err          = r_err;
    assign result       = r_result;
    assign bus.bus_data = r_data;
    assign bus.bus_wr   = r_wr;
    assign bus.bus_rd   = r_rd;

endmodule

// File: tb/tb_herald_host.sv
// tb_herald_host -- randomized self-checking bench for herald_host.
// A behavioural peripheral serves BUSY and read bytes; a transaction-level
// model (expected write byte list, read count, outcome, assembled result) is
// compared against the DUT on every falling clock edge.
module tb_herald_host;

    localparam int unsigned S = 3;
    localparam int unsigned T = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cmd;
    logic [23:0] op_a;
    logic [23:0] op_b;
    logic        ready;
    logic        done;
    logic        err;
    logic [71:0] result;

    herald_host_if bus ();

    herald_host #(
        .STROBE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cmd   (cmd),
        .op_a  (op_a),
        .op_b  (op_b),
        .ready (ready),
        .done  (done),
        .err   (err),
        .result(result),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    logic [7:0]  exp_wr[$];
    logic [7:0]  obs_wr[$];
    logic [7:0]  served[$];
    logic [7:0]  dir_rd[$];
    int          exp_nrd;
    bit          exp_err;
    bit          exp_timeout;
    bit          in_txn = 1'b0;
    logic [71:0] model_result = '0;
    int          n_rd_obs = 0;
    int          nwr_obs  = 0;

    bit          hang = 1'b0;
    int unsigned busy_len = 0;

    function automatic void decode(input logic [7:0] c, output bit ok, output int nops, output int nrd);
        ok = 1'b1;
        nops = 0;
        nrd = 0;
        case (c)
            8'h10:                      begin nops = 3; nrd = 6; end
            8'h11, 8'h12, 8'h20, 8'h21: begin nops = 6; nrd = 3; end
            8'h13:                      begin nops = 6; nrd = 9; end
            8'h23:                      begin nops = 3; nrd = 3; end
            8'h22:                      begin nops = 0; nrd = 0; end
            default:                    ok = 1'b0;
        endcase
    endfunction

    function automatic void set_model(input logic [7:0] c, input logic [23:0] a,
                                      input logic [23:0] b, input bit hng);
        bit ok;
        int nops, nrd;
        decode(c, ok, nops, nrd);
        exp_wr.delete();
        obs_wr.delete();
        served.delete();
        n_rd_obs = 0;
        nwr_obs  = 0;
        if (ok) begin
            exp_wr.push_back(c);
            for (int i = 0; i < nops; i++) begin
                if (i < 3) exp_wr.push_back(a[8*i +: 8]);
                else       exp_wr.push_back(b[8*(i-3) +: 8]);
            end
        end
        exp_nrd      = nrd;
        exp_err      = !ok || hng;
        exp_timeout  = ok && hng;
        model_result = '0;
        in_txn       = 1'b1;
    endfunction

    // ---------------- peripheral ----------------
    int          busy_ctr = 0;
    int          per_rd_hi = 0;
    logic [7:0]  per_byte;

    initial bus.bus_in = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_ctr   = 0;
            per_rd_hi  = 0;
            bus.bus_in = 8'h00;
        end else begin
            if (bus.bus_wr) busy_ctr = hang ? 32'h3fff_ffff : int'(busy_len);
            else if (busy_ctr > 0) busy_ctr--;
            if (bus.bus_rd) per_rd_hi++;
            else per_rd_hi = 0;
            if (per_rd_hi == 2) begin
                if (dir_rd.size() != 0) per_byte = dir_rd.pop_front();
                else per_byte = 8'($urandom);
                served.push_back(per_byte);
                bus.bus_in = per_byte;
            end else begin
                bus.bus_in = {busy_ctr > 0, 7'($urandom)};
            end
        end
    end

    // ---------------- compare process ----------------
    bit          prev_wr = 0, prev_rd = 0, prev_done = 0, prev_err = 0;
    int          wr_hi = 0, wr_gap = 0, rd_hi_m = 0, rd_gap = 0, since_fall = 1000;
    logic [7:0]  wr_hold = '0;
    logic [71:0] mon_asm;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr = 0; prev_rd = 0; prev_done = 0; prev_err = 0;
            wr_hi = 0; rd_hi_m = 0; since_fall = 1000;
        end else begin
            check("wr_rd_excl", bus.bus_wr & bus.bus_rd, 0);
            check("done_err_excl", done & err, 0);
            check("done_pulse", done & prev_done, 0);
            check("err_pulse", err & prev_err, 0);
            check("done_not_ready", done & ready, 0);
            if (ready) begin
                check("idle_no_strobe", bus.bus_wr | bus.bus_rd, 0);
                check("idle_result", result, model_result);
            end

            if (bus.bus_wr && !prev_wr) begin
                if (nwr_obs > 0) check("wr_period", wr_gap, 2 * S);
                check("wr_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) check("wr_byte", bus.bus_data, exp_wr.pop_front());
                obs_wr.push_back(bus.bus_data);
                nwr_obs++;
                wr_hold = bus.bus_data;
                wr_hi   = 1;
                wr_gap  = 1;
            end else begin
                wr_gap++;
                if (bus.bus_wr) begin
                    wr_hi++;
                    check("wr_data_stable", bus.bus_data, wr_hold);
                end
            end
            if (!bus.bus_wr && prev_wr) begin
                check("wr_high_width", wr_hi, S);
                since_fall = 1;
            end else if (!bus.bus_wr) begin
                since_fall++;
            end
            if (!bus.bus_wr && since_fall <= S && nwr_obs > 0)
                check("wr_data_hold_low", bus.bus_data, wr_hold);

            if (bus.bus_rd && !prev_rd) begin
                if (n_rd_obs > 0) check("rd_period", rd_gap, 2 * S);
                check("rd_allowed", {exp_err, exp_wr.size() == 0}, 2'b01);
                n_rd_obs++;
                rd_hi_m = 1;
                rd_gap  = 1;
            end else begin
                rd_gap++;
                if (bus.bus_rd) rd_hi_m++;
            end
            if (!bus.bus_rd && prev_rd) check("rd_high_width", rd_hi_m, S);

            if (done) begin
                check("done_expected", in_txn && !exp_err, 1);
                check("done_writes_left", exp_wr.size(), 0);
                check("done_reads", n_rd_obs, exp_nrd);
                mon_asm = '0;
                for (int k = 0; k < served.size() && k < 9; k++) mon_asm[8*k +: 8] = served[k];
                check("done_result", result, mon_asm);
                model_result = mon_asm;
                in_txn = 1'b0;
            end
            if (err) begin
                check("err_expected", in_txn && exp_err, 1);
                check("err_reads", n_rd_obs, 0);
                if (exp_timeout) check("timeout_latency", since_fall, S + T + 1);
                in_txn = 1'b0;
            end

            prev_wr   = bus.bus_wr;
            prev_rd   = bus.bus_rd;
            prev_done = done;
            prev_err  = err;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        check("ready_wait_bound", got, 1);
    endtask

    task automatic wait_end(input bit noise);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done || err) begin
                got = 1'b1;
                break;
            end
            // Starts and input changes while busy must have no effect.
            if (noise && !ready && $urandom_range(0, 5) == 0) begin
                start = 1'b1;
                cmd   = 8'($urandom);
                op_a  = 24'($urandom);
                op_b  = 24'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("txn_end_bound", got, 1);
    endtask

    task automatic launch(input logic [7:0] c, input logic [23:0] a, input logic [23:0] b,
                          input bit hng, input int unsigned blen);
        hang     = hng;
        busy_len = blen;
        start    = 1'b1;
        cmd      = c;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        set_model(c, a, b, hng);
    endtask

    task automatic run_txn(input logic [7:0] c, input logic [23:0] a, input logic [23:0] b,
                           input bit hng, input int unsigned blen, input bit noise);
        bit ok;
        int nops, nrd;
        decode(c, ok, nops, nrd);
        wait_ready();
        launch(c, a, b, hng, blen);
        if (!ok) begin
            @(negedge clk);
            check("unknown_err_cycle", {done, err, ready}, 3'b011);
            @(negedge clk);
            check("unknown_after", {done, err, ready}, 3'b001);
        end else begin
            wait_end(noise);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_done_err"}, {done, err}, 2'b00);
        check({tag, "_result"}, result, 72'h0);
        check({tag, "_bus_data"}, bus.bus_data, 8'h00);
        check({tag, "_strobes"}, {bus.bus_wr, bus.bus_rd}, 2'b00);
    endtask

    logic [7:0] mul_wr[7];
    logic [7:0] valid_cmds[8];

    initial begin
        bit          ok;
        int          nops, nrd;
        logic [7:0]  c;
        int unsigned r;

        mul_wr     = '{8'h20, 8'h00, 8'h10, 8'h00, 8'h00, 8'h20, 8'h00};
        valid_cmds = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
        rst_n = 1'b0;
        start = 1'b0;
        cmd   = '0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // MUL: three served bytes 00,20,00 assemble to 0x002000.
        dir_rd.delete();
        dir_rd.push_back(8'h00); dir_rd.push_back(8'h20); dir_rd.push_back(8'h00);
        run_txn(8'h20, 24'h001000, 24'h002000, 1'b0, 5, 1'b0);
        check("mul_nwr", obs_wr.size(), 7);
        if (obs_wr.size() == 7)
            for (int i = 0; i < 7; i++) check("mul_wr_byte", obs_wr[i], mul_wr[i]);
        check("mul_nrd", n_rd_obs, 3);
        check("mul_result", result, 72'h002000);

        // SINCOS: A only, six result bytes.
        run_txn(8'h10, 24'h000C91, 24'hABCDEF, 1'b0, 8, 1'b0);
        check("sincos_nwr", obs_wr.size(), 4);
        if (obs_wr.size() == 4) check("sincos_a_bytes", {obs_wr[1], obs_wr[2], obs_wr[3]}, 24'h910C00);
        check("sincos_nrd", n_rd_obs, 6);
        check("sincos_upper_zero", result[71:48], 24'h0);

        // NORMALIZE then CLEAR.
        run_txn(8'h13, 24'h123456, 24'h789ABC, 1'b0, 3, 1'b0);
        check("norm_nwr", obs_wr.size(), 7);
        check("norm_nrd", n_rd_obs, 9);
        run_txn(8'h22, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 0, 1'b0);
        check("clear_nwr", obs_wr.size(), 1);
        check("clear_nrd", n_rd_obs, 0);
        check("clear_result", result, 72'h0);

        // Unknown command, then BUSY timeout.
        run_txn(8'h30, 24'h0, 24'h0, 1'b0, 0, 1'b0);
        run_txn(8'h21, 24'h111111, 24'h222222, 1'b1, 0, 1'b0);
        check("timeout_nrd", n_rd_obs, 0);

        // Reset in the middle of the read phase.
        wait_ready();
        launch(8'h13, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 4);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (n_rd_obs >= 4) break;
        end
        check("midread_reached", n_rd_obs >= 4, 1);
        repeat (2 * S) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        in_txn = 1'b0;
        model_result = '0;
        exp_wr.delete();
        hang = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("held_reset");
        rst_n = 1'b1;
        launch(8'h13, 24'h0F0F0F, 24'hF0F0F0, 1'b0, 6);
        @(negedge clk);
        check("accept_first_edge", ready, 0);
        wait_end(1'b0);
        check("post_reset_nrd", n_rd_obs, 9);

        // Randomized traffic with start noise during transactions.
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do begin
                    c = 8'($urandom);
                    decode(c, ok, nops, nrd);
                end while (ok);
            end else begin
                c = valid_cmds[$urandom_range(0, 7)];
            end
            run_txn(c, 24'($urandom), 24'($urandom), r == 1, $urandom_range(0, 25), 1'b1);
        end
        wait_ready();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/herald_host.md
HERALD_HOST -- requirements
Module: herald_host

Interface
REQ-001 SHALL provide parameter STROBE_CYCLES, default 2, strobe high-phase and low-phase width in clocks (legal range 2..15).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 4095, maximum clocks spent waiting for BUSY low before an error.
REQ-003 SHALL provide ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  launch request; sampled only while ready=1.
- cmd  in  8  command code.
- op_a  in  24  operand A, Q12.12.
- op_b  in  24  operand B, Q12.12.
- ready  out  1  host idle, accepting start.
- done  out  1  one-cycle pulse, transaction complete.
- err  out  1  one-cycle pulse, transaction rejected or timed out.
- result  out  72  result bytes packed LSB-first, zero-extended.
- bus_data  out  8  byte driven to peripheral data input.
- bus_wr  out  1  write strobe, registered.
- bus_rd  out  1  read strobe, registered.
- bus_in  in  8  peripheral output bus; bit 7 = BUSY.

Function
REQ-004 SHALL latch cmd, op_a, op_b on the cycle start=1 and ready=1; start while ready=0 SHALL be ignored.
REQ-005 SHALL decode operand/result byte counts: 0x10 -> A only, 6 bytes; 0x11/0x12 -> A+B, 3; 0x13 -> A+B, 9; 0x20/0x21 -> A+B, 3; 0x23 -> A only, 3; 0x22 -> none, 0.
REQ-006 SHALL, for any other cmd, pulse err the cycle after acceptance, generate no strobe, and return to IDLE.
REQ-007 SHALL implement states IDLE, WR_CMD, WR_OPS, WAIT_BUSY, RD_BYTES, FINISH.
REQ-008 SHALL perform each byte write as: bus_data set, bus_wr=1 for STROBE_CYCLES, bus_wr=0 for STROBE_CYCLES; bus_data held stable throughout both phases.
REQ-009 SHALL write the cmd byte, then operand A bytes [7:0],[15:8],[23:16], then (if required) operand B in the same order.
REQ-010 SHALL enter WAIT_BUSY after the last write's low phase and leave on the first cycle bus_in[7]=0.
REQ-011 SHALL, in WAIT_BUSY, count clocks; reaching TIMEOUT_CYCLES with bus_in[7]=1 SHALL pulse err and return to IDLE.
REQ-012 SHALL perform each byte read as: bus_rd=1 for STROBE_CYCLES then 0 for STROBE_CYCLES; bus_in captured exactly on the second cycle of the high phase (one clock after bus_rd rises).
REQ-013 SHALL store read byte k into result[8k+7:8k], k = 0..N-1; unread bytes remain 0.
REQ-014 SHALL, for 0x22, skip RD_BYTES after BUSY low and pulse done with result=0.
REQ-015 SHALL pulse done for one cycle in FINISH, then return to IDLE; result holds until the next accepted start, which clears it to 0.
REQ-016 SHALL keep bus_wr and bus_rd mutually exclusive and both 0 in IDLE, WAIT_BUSY and FINISH.
REQ-017 SHALL drive ready=1 only in IDLE; done and err never asserted together.

Reset
REQ-018 SHALL, on rst_n=0 at any time including mid-transaction, immediately force: state IDLE, ready=1, done=0, err=0, result=0, bus_data=0, bus_wr=0, bus_rd=0, counters 0.
REQ-019 SHALL accept start on the first clock edge after rst_n deasserts.

Verification
REQ-020 MUL: cmd=0x20, A=0x001000, B=0x002000, model returns 0x00,0x20,0x00 -> bus writes 0x20,0x00,0x10,0x00,0x00,0x20,0x00; 3 reads; result=0x002000; done one pulse.
REQ-021 SINCOS: cmd=0x10, A=0x000C91 -> 4 writes, 6 reads; result[47:0]=model bytes; result[71:48]=0.
REQ-022 NORMALIZE + CLEAR: cmd=0x13 -> 7 writes, 9 reads, full 72-bit result; then cmd=0x22 -> 1 write, 0 reads, done, result=0.
REQ-023 Unknown cmd=0x30 -> err one pulse one cycle after start, bus_wr/bus_rd never asserted, ready=1 next cycle.
REQ-024 Timeout: model holds bus_in=0x80 after last write -> err after TIMEOUT_CYCLES, no read strobes.
REQ-025 Reset mid-read (cmd=0x13, after 4th read) -> all outputs to reset values asynchronously; next start runs a full transaction correctly.
